// File: rtl/ckong_nvram_upload_if.sv
// HPS ioctl upload-direction signals plus the work-RAM read port of the Crazy Kong core.
// The slave side is the responder; the master side is the HPS/RAM environment.
interface ckong_nvram_upload_if #(
    parameter int ADDR_W = 11
);
    logic              ioctl_upload;
    logic              ioctl_rd;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_din;
    logic              ioctl_wait;
    logic              ram_req;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_ack;
    logic [7:0]        ram_dout;

    modport slave (
        input  ioctl_upload, ioctl_rd, ioctl_addr, ram_ack, ram_dout,
        output ioctl_din, ioctl_wait, ram_req, ram_addr
    );

    modport master (
        output ioctl_upload, ioctl_rd, ioctl_addr, ram_ack, ram_dout,
        input  ioctl_din, ioctl_wait, ram_req, ram_addr
    );
endinterface

// File: rtl/ckong_nvram_upload.sv
// Serves work-RAM bytes to the HPS on ioctl_rd; >=3 clocks strobe-to-data (1 for out of range).
// Stalls the HPS with ioctl_wait until vblank (or timeout) and the RAM grant; all outputs registered.
module ckong_nvram_upload #(
    parameter int                ADDR_W  = 11,
    parameter int                DEPTH   = 256,
    parameter logic [ADDR_W-1:0] BASE    = '0,
    parameter logic [19:0]       TIMEOUT = 20'd800000
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    ckong_nvram_upload_if.slave bus,
    input  logic                vblank,
    output logic [15:0]         byte_count,
    output logic                timeout_flag
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT_VBL, S_REQ, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_upload_d;
    logic [19:0]       r_tmo_cnt;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [7:0]        r_din;
    logic              r_wait;
    logic              r_req;
    logic [15:0]       r_byte_count;
    logic              r_timeout_flag;

    logic              w_in_range;
    logic              w_tmo_hit;
    logic              w_upload_rise;
    logic              w_latch;
    logic              w_capture;
    logic              w_load_ff;
    logic              w_tmo_set;
    logic [15:0]       w_cnt_base;
    logic [15:0]       w_cnt_next;

    assign w_in_range    = bus.ioctl_addr < 25'(DEPTH);
    assign w_tmo_hit     = (r_tmo_cnt == TIMEOUT - 20'd1);
    assign w_upload_rise = bus.ioctl_upload & ~r_upload_d;

    always_comb begin
        w_next    = r_state;
        w_latch   = 1'b0;
        w_capture = 1'b0;
        w_load_ff = 1'b0;
        w_tmo_set = 1'b0;
        if (r_state != S_IDLE && !bus.ioctl_upload) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.ioctl_rd && bus.ioctl_upload) begin
                        if (w_in_range) begin
                            w_next  = S_WAIT_VBL;
                            w_latch = 1'b1;
                        end else begin
                            w_next    = S_DONE;
                            w_load_ff = 1'b1;
                        end
                    end
                end
                S_WAIT_VBL: begin
                    // vblank wins when it coincides with the timeout, so the flag only marks true forcing
                    if (vblank) begin
                        w_next = S_REQ;
                    end else if (w_tmo_hit) begin
                        w_next    = S_REQ;
                        w_tmo_set = 1'b1;
                    end
                end
                S_REQ: begin
                    if (bus.ram_ack) begin
                        w_next    = S_DONE;
                        w_capture = 1'b1;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // A read completing on the same edge as a session start counts into the new session
    always_comb begin
        w_cnt_base = w_upload_rise ? 16'd0 : r_byte_count;
        w_cnt_next = w_cnt_base;
        if ((w_capture || w_load_ff) && w_cnt_base != 16'hFFFF) begin
            w_cnt_next = w_cnt_base + 16'd1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_upload_d     <= 1'b0;
            r_tmo_cnt      <= '0;
            r_ram_addr     <= '0;
            r_din          <= '0;
            r_wait         <= 1'b0;
            r_req          <= 1'b0;
            r_byte_count   <= '0;
            r_timeout_flag <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_upload_d     <= bus.ioctl_upload;
            r_wait         <= (w_next == S_WAIT_VBL) || (w_next == S_REQ);
            r_req          <= (w_next == S_REQ);
            r_byte_count   <= w_cnt_next;
            r_timeout_flag <= w_tmo_set | (r_timeout_flag & ~w_upload_rise);
            if (r_state != S_WAIT_VBL) begin
                r_tmo_cnt <= '0;
            end else if (!w_tmo_hit) begin
                r_tmo_cnt <= r_tmo_cnt + 20'd1;
            end
            if (w_latch) begin
                r_ram_addr <= BASE + bus.ioctl_addr[ADDR_W-1:0];
            end
            if (w_capture) begin
                r_din <= bus.ram_dout;
            end else if (w_load_ff) begin
                r_din <= 8'hFF;
            end
        end
    end

    assign bus.ioctl_din  = r_din;
    assign bus.ioctl_wait = r_wait;
    assign bus.ram_req    = r_req;
    assign bus.ram_addr   = r_ram_addr;
    assign byte_count     = r_byte_count;
    assign timeout_flag   = r_timeout_flag;
endmodule

// File: tb/tb_ckong_nvram_upload.sv
// Randomized upload reads against a transaction-level model of latency, data, count and timeout flag.
module tb_ckong_nvram_upload;
    localparam int              AW    = 11;
    localparam int              DEPTH = 256;
    localparam int              TMO   = 128;
    localparam logic [AW-1:0]   BASE  = 11'h7C0;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        vblank;
    logic [15:0] byte_count;
    logic        timeout_flag;

    ckong_nvram_upload_if #(.ADDR_W(AW)) bus();

    ckong_nvram_upload #(
        .ADDR_W (AW),
        .DEPTH  (DEPTH),
        .BASE   (BASE),
        .TIMEOUT(20'(TMO))
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .bus         (bus.slave),
        .vblank      (vblank),
        .byte_count  (byte_count),
        .timeout_flag(timeout_flag)
    );

    initial forever #5 clk_sys = ~clk_sys;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  mem [2048];
    int          m_cnt;
    bit          m_flag;
    logic [7:0]  m_din;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_session();
        @(negedge clk_sys);
        bus.ioctl_upload = 1'b0;
        @(negedge clk_sys);
        bus.ioctl_upload = 1'b1;
        @(negedge clk_sys);
        m_cnt  = 0;
        m_flag = 1'b0;
        check("sess_cnt", 32'(byte_count), 32'(m_cnt));
        check("sess_flag", 32'(timeout_flag), 32'(m_flag));
    endtask

    // vd: cycles of vblank=0 after the strobe; s: cycles of ram_ack withheld once ram_req is up
    task automatic do_read(input logic [24:0] addr, input int vd, input int s, input bit spurious);
        bit         in_rng;
        int         w, exp_lat, ea, c, wait_n, req_n, old_cnt;
        bit         got_done;
        logic [7:0] ed;
        logic [31:0] rnd;
        in_rng  = (addr < 25'(DEPTH));
        w       = (vd + 1 < TMO) ? vd + 1 : TMO;
        exp_lat = in_rng ? 2 + w + s : 1;
        ea      = (int'(BASE) + int'(addr[10:0])) % 2048;
        ed      = in_rng ? mem[ea] : 8'hFF;
        old_cnt = m_cnt;
        if (in_rng && vd >= TMO) m_flag = 1'b1;
        if (m_cnt != 65535) m_cnt++;
        m_din = ed;

        bus.ioctl_rd   = 1'b1;
        bus.ioctl_addr = addr;
        vblank         = 1'b0;
        bus.ram_ack    = 1'b0;
        c = 0; wait_n = 0; req_n = 0; got_done = 1'b0;
        while (!got_done && c < 400) begin
            @(negedge clk_sys);
            c++;
            if (bus.ioctl_wait) wait_n++;
            if (bus.ram_req) begin
                req_n++;
                if (req_n == 1) check("ram_addr", 32'(bus.ram_addr), 32'(ea));
            end
            if (byte_count != 16'(old_cnt)) begin
                got_done = 1'b1;
            end else begin
                bus.ioctl_rd = spurious && (c == 1);
                if (spurious && c == 1) begin
                    rnd = $urandom;
                    bus.ioctl_addr = rnd[24:0];
                end
                vblank      = (c > vd);
                bus.ram_ack = bus.ram_req && (req_n > s);
                bus.ram_dout = bus.ram_ack ? mem[int'(bus.ram_addr)] : 8'($urandom);
            end
        end
        bus.ioctl_rd = 1'b0;
        bus.ram_ack  = 1'b0;
        check("latency", 32'(c), 32'(exp_lat));
        check("din", 32'(bus.ioctl_din), 32'(ed));
        check("count", 32'(byte_count), 32'(m_cnt));
        check("wait_cycles", 32'(wait_n), in_rng ? 32'(exp_lat - 1) : 32'd0);
        check("req_cycles", 32'(req_n), in_rng ? 32'(s + 1) : 32'd0);
        check("tmo_flag", 32'(timeout_flag), 32'(m_flag));
        @(negedge clk_sys);
        check("hold_din", 32'(bus.ioctl_din), 32'(m_din));
        check("idle_wait", 32'(bus.ioctl_wait), 32'd0);
    endtask

    logic [24:0] t_addr;
    logic [31:0] t_rnd;
    int          t_vd;
    int          t_ea;
    logic [7:0]  t_bad;

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
        mem[(int'(BASE) + 5) % 2048] = 8'h3C;
        reset_n          = 1'b0;
        vblank           = 1'b0;
        bus.ioctl_upload = 1'b0;
        bus.ioctl_rd     = 1'b0;
        bus.ioctl_addr   = '0;
        bus.ram_ack      = 1'b0;
        bus.ram_dout     = '0;
        m_cnt  = 0;
        m_flag = 1'b0;
        m_din  = 8'h00;

        repeat (5) @(negedge clk_sys);
        check("rst_din", 32'(bus.ioctl_din), 32'd0);
        check("rst_wait", 32'(bus.ioctl_wait), 32'd0);
        check("rst_req", 32'(bus.ram_req), 32'd0);
        check("rst_addr", 32'(bus.ram_addr), 32'd0);
        check("rst_cnt", 32'(byte_count), 32'd0);
        check("rst_flag", 32'(timeout_flag), 32'd0);
        reset_n = 1'b1;

        start_session();
        do_read(25'd5, 0, 0, 1'b0);
        do_read(25'd9, 99, 0, 1'b0);
        do_read(25'd300, 0, 0, 1'b0);
        do_read(25'd255, 1, 2, 1'b1);
        do_read(25'd256, 0, 0, 1'b1);
        do_read(25'd40, 1000, 1, 1'b0);
        do_read(25'd6, 0, 0, 1'b1);

        // abort while in REQ with a simultaneous grant
        t_ea  = (int'(BASE) + 7) % 2048;
        t_bad = ~mem[t_ea];
        bus.ioctl_rd   = 1'b1;
        bus.ioctl_addr = 25'd7;
        vblank         = 1'b1;
        @(negedge clk_sys);
        bus.ioctl_rd = 1'b0;
        check("abort_wait1", 32'(bus.ioctl_wait), 32'd1);
        @(negedge clk_sys);
        check("abort_req1", 32'(bus.ram_req), 32'd1);
        bus.ioctl_upload = 1'b0;
        bus.ram_ack      = 1'b1;
        bus.ram_dout     = t_bad;
        @(negedge clk_sys);
        bus.ram_ack = 1'b0;
        check("abort_req0", 32'(bus.ram_req), 32'd0);
        check("abort_wait0", 32'(bus.ioctl_wait), 32'd0);
        check("abort_din", 32'(bus.ioctl_din), 32'(m_din));
        check("abort_cnt", 32'(byte_count), 32'(m_cnt));

        // a strobe outside a session is ignored
        bus.ioctl_rd   = 1'b1;
        bus.ioctl_addr = 25'd5;
        @(negedge clk_sys);
        bus.ioctl_rd = 1'b0;
        @(negedge clk_sys);
        check("nosess_wait", 32'(bus.ioctl_wait), 32'd0);
        check("nosess_req", 32'(bus.ram_req), 32'd0);
        check("nosess_cnt", 32'(byte_count), 32'(m_cnt));
        check("nosess_din", 32'(bus.ioctl_din), 32'(m_din));

        start_session();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) start_session();
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: t_addr = 25'($urandom_range(0, DEPTH - 1));
                6, 7:             t_addr = 25'($urandom_range(DEPTH, 4095));
                default: begin
                    t_rnd  = $urandom;
                    t_addr = t_rnd[24:0];
                end
            endcase
            t_vd = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TMO, TMO + 20))
                                               : int'($urandom_range(0, 6));
            do_read(t_addr, t_vd, int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
